// File: rtl/lcd_page_writer.sv
// lcd_page_writer: reads two text lines from the character BRAM and writes
// them to an HD44780 LCD over the 4-bit bus (set-address command, then data
// bytes, each sent as high nibble then low nibble with an enable strobe).
module lcd_page_writer #(
  parameter logic [10:0] LINE1_BASE = 11'h000,
  parameter logic [10:0] LINE2_BASE = 11'h018,
  parameter int unsigned LINE_LEN   = 16,
  parameter logic [7:0]  TERM_CHAR  = 8'hFF,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 12,
  parameter int unsigned NIBBLE_GAP = 50,
  parameter int unsigned BYTE_WAIT  = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [3:0]  lcd_d,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);

  typedef enum logic [3:0] {
    IDLE, CMD, FETCH, LATCH, NIB_HI, NIB_LO, WAIT, NEXT, FIN
  } state_t;

  // Sub-phases of one nibble transfer: data setup, enable high, post-fall gap.
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_GAP} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  byte_q, byte_n;
  logic        rs_q, rs_n;
  logic        line, line_n;
  logic [10:0] ptr, ptr_n;
  logic [4:0]  char_cnt, char_n;
  logic [3:0]  d_q, d_n;
  logic        e_q, e_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;

  // The pointer drives the BRAM directly so the data arrives in LATCH,
  // one cycle after FETCH.
  assign rom_addr = ptr;
  assign lcd_d    = d_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= PH_SETUP;
      cnt      <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      line     <= 1'b0;
      ptr      <= '0;
      char_cnt <= '0;
      d_q      <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      byte_q   <= byte_n;
      rs_q     <= rs_n;
      line     <= line_n;
      ptr      <= ptr_n;
      char_cnt <= char_n;
      d_q      <= d_n;
      e_q      <= e_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output logic for the page walk.
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    byte_n  = byte_q;
    rs_n    = rs_q;
    line_n  = line;
    ptr_n   = ptr;
    char_n  = char_cnt;
    d_n     = d_q;
    e_n     = e_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          busy_n  = 1'b1;
          line_n  = 1'b0;
          ptr_n   = LINE1_BASE;
          char_n  = '0;
          byte_n  = 8'h80;
          rs_n    = 1'b0;
          cnt_n   = '0;
          phase_n = PH_SETUP;
          state_n = CMD;
        end
      end
      CMD: begin
        d_n     = byte_q[7:4];
        state_n = NIB_HI;
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        if (rom_data == TERM_CHAR) begin
          state_n = NEXT;
        end else begin
          byte_n  = rom_data;
          rs_n    = 1'b1;
          d_n     = rom_data[7:4];
          ptr_n   = ptr + 11'd1;
          char_n  = char_cnt + 5'd1;
          state_n = NIB_HI;
        end
      end
      NIB_HI, NIB_LO: begin
        cnt_n = cnt + 16'd1;
        case (phase)
          PH_SETUP: if (cnt == 16'(SETUP_CYC - 1)) begin
            phase_n = PH_PULSE;
            cnt_n   = '0;
            e_n     = 1'b1;
          end
          PH_PULSE: if (cnt == 16'(PULSE_CYC - 1)) begin
            phase_n = PH_GAP;
            cnt_n   = '0;
            e_n     = 1'b0;
          end
          PH_GAP: if (cnt == 16'(NIBBLE_GAP - 1)) begin
            phase_n = PH_SETUP;
            cnt_n   = '0;
            if (state == NIB_HI) begin
              d_n     = byte_q[3:0];
              state_n = NIB_LO;
            end else begin
              state_n = WAIT;
            end
          end
          default: phase_n = PH_SETUP;
        endcase
      end
      WAIT: begin
        cnt_n = cnt + 16'd1;
        if (cnt == 16'(BYTE_WAIT - 1)) begin
          cnt_n = '0;
          // Line-address commands are always followed by the first fetch.
          if (rs_q && char_cnt == 5'(LINE_LEN)) state_n = NEXT;
          else                                  state_n = FETCH;
        end
      end
      NEXT: begin
        if (!line) begin
          line_n  = 1'b1;
          ptr_n   = LINE2_BASE;
          char_n  = '0;
          byte_n  = 8'hC0;
          rs_n    = 1'b0;
          d_n     = 4'hC;
          state_n = NIB_HI;
        end else begin
          state_n = FIN;
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_page_writer.sv
// Bench for lcd_page_writer: decodes the LCD bus into a byte stream and
// compares it with a page built directly from the BRAM contents.
module tb_lcd_page_writer;

  localparam int unsigned S = 1, P = 2, G = 2, W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        a_busy, a_done, a_rs, a_rw, a_e;
  logic        b_busy, b_done, b_rs, b_rw, b_e;
  logic [10:0] a_addr, b_addr;
  logic [3:0]  a_d, b_d;
  logic [7:0]  rom_data_a, rom_data_b;
  logic [7:0]  mem [0:2047];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data_a <= mem[a_addr];
    rom_data_b <= mem[b_addr];
  end

  lcd_page_writer #(.SETUP_CYC(S), .PULSE_CYC(P), .NIBBLE_GAP(G), .BYTE_WAIT(W)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
    .rom_addr(a_addr), .rom_data(rom_data_a), .lcd_d(a_d), .lcd_rs(a_rs),
    .lcd_rw(a_rw), .lcd_e(a_e));

  lcd_page_writer #(.LINE1_BASE(11'h020), .SETUP_CYC(S), .PULSE_CYC(P),
                    .NIBBLE_GAP(G), .BYTE_WAIT(W)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .rom_addr(b_addr), .rom_data(rom_data_b), .lcd_d(b_d), .lcd_rs(b_rs),
    .lcd_rw(b_rw), .lcd_e(b_e));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: watches whichever instance is selected.
  logic       sel = 1'b0;
  logic       m_e, m_rs, m_busy, m_done;
  logic [3:0] m_d;
  assign m_e    = sel ? b_e    : a_e;
  assign m_rs   = sel ? b_rs   : a_rs;
  assign m_d    = sel ? b_d    : a_d;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         done_cnt = 0, pulse_cnt = 0, hi_cnt = 0, low_cnt = 100;
  logic       prev_e = 1'b0, prev_rs = 1'b0, rise_rs = 1'b0, half = 1'b0;
  logic [3:0] prev_d = '0, rise_d = '0, hi_nib = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e = 1'b0; half = 1'b0; hi_cnt = 0; low_cnt = 100;
    end else begin
      if (m_done) done_cnt++;
      if (m_e && !prev_e) begin
        check("setup_d", 32'(prev_d), 32'(m_d));
        check("setup_rs", 32'(prev_rs), 32'(m_rs));
        check("nibble_gap", 32'(low_cnt >= 2), 1);
        rise_d = m_d; rise_rs = m_rs; hi_cnt = 1; pulse_cnt++;
      end else if (m_e) begin
        hi_cnt++;
      end else if (prev_e) begin
        check("pulse_width", hi_cnt, P);
        check("hold_d", 32'(m_d), 32'(rise_d));
        check("hold_rs", 32'(m_rs), 32'(rise_rs));
        if (!half) begin
          hi_nib = rise_d; half = 1'b1;
        end else begin
          got_q.push_back({rise_rs, hi_nib, rise_d});
          half = 1'b0;
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_e = m_e; prev_d = m_d; prev_rs = m_rs;
    end
  end

  // Reference page: address command, then characters up to the terminator
  // or 16 per line, for each of the two lines.
  task automatic build_exp(input logic [10:0] base1);
    logic [10:0] base, a;
    logic [7:0]  c;
    exp_q.delete();
    for (int ln = 0; ln < 2; ln++) begin
      base = (ln == 0) ? base1 : 11'h018;
      exp_q.push_back({1'b0, (ln == 0) ? 8'h80 : 8'hC0});
      for (int i = 0; i < 16; i++) begin
        a = base + 11'(i);
        c = mem[a];
        if (c == 8'hFF) break;
        exp_q.push_back({1'b1, c});
      end
    end
  endtask

  task automatic pulse_start(input logic s);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic run_page(input logic s, input int mid_start);
    int cyc;
    sel = s;
    got_q.delete();
    done_cnt = 0; pulse_cnt = 0;
    build_exp(s ? 11'h020 : 11'h000);
    @(posedge clk); #1;
    pulse_start(s);
    check("busy_after_start", 32'(m_busy), 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      if (cyc == mid_start && mid_start > 0) pulse_start(s);
      else begin @(posedge clk); #1; end
      cyc++;
    end
    check("done_timeout", 32'(done_cnt != 0), 1);
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", done_cnt, 1);
    check("busy_end", 32'(m_busy), 0);
    check("stream_len", got_q.size(), exp_q.size());
    check("pulse_count", pulse_cnt, 2 * exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("stream_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  initial begin
    int k;
    for (int a = 0; a < 2048; a++) mem[a] = 8'h2E;
    for (int a = 0; a < 16; a++) mem[a] = 8'h41 + 8'(a);
    for (int a = 0; a < 16; a++) mem[24 + a] = 8'h61 + 8'(a);
    mem[11'h028] = 8'hFF;
    mem[11'h029] = 8'h20;

    // Reset state, then idle with no start.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_lcd", 32'({a_d, a_rs, a_rw, a_e}), 0);
    check("rst_b", 32'({b_busy, b_done, b_addr, b_d, b_rs, b_rw, b_e}), 0);
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("idle_a", 32'({a_busy, a_done, a_addr, a_d, a_rs, a_rw, a_e}), 0);
    check("idle_b", 32'({b_busy, b_done, b_addr, b_d, b_rs, b_rw, b_e}), 0);

    run_page(1'b0, 0);      // default page
    run_page(1'b1, 0);      // line 1 ends at a terminator
    run_page(1'b0, 100);    // start during busy is ignored

    // Asynchronous reset while the enable strobe is high.
    sel = 1'b0;
    pulse_start(1'b0);
    k = 0;
    while (!a_e && k < 200) begin @(negedge clk); k++; end
    check("e_seen", 32'(a_e), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", 32'(a_e), 0);
    check("async_rst_busy", 32'(a_busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_page(1'b0, 0);

    // Random BRAM contents with occasional terminators.
    repeat (4) begin
      for (int a = 0; a < 2048; a++)
        mem[a] = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
      run_page(1'($urandom_range(1)), ($urandom_range(1) == 1) ? int'($urandom_range(300, 20)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
